// File: rtl/drum_pkg.sv
// Shared drum-machine types: the system mode encoding used by the mode controller
// and the default step_sequencer geometry.
package drum_pkg;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    PLAY = 2'd1,
    RAW  = 2'd2
  } sysmode_t;

  localparam int DRUM_VOICES   = 4;
  localparam int DRUM_STEPS    = 16;
  localparam int DRUM_PERIOD_W = 24;

  // The mode controller never emits 3, but if it does, it behaves like EDIT.
  function automatic sysmode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return PLAY;
      2'd2:    return RAW;
      default: return EDIT;
    endcase
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control/status bundle between the sequencer (slave) and its driver (master):
// mode, edit controls and pads in; triggers and step/pattern status out.
interface step_sequencer_if import drum_pkg::*; #(
  parameter int VOICES   = DRUM_VOICES,
  parameter int STEPS    = DRUM_STEPS,
  parameter int PERIOD_W = DRUM_PERIOD_W
);
  localparam int STEP_W  = $clog2(STEPS);
  localparam int VOICE_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic [1:0]          mode;
  logic [PERIOD_W-1:0] step_period;
  logic [STEP_W-1:0]   edit_step;
  logic [VOICE_W-1:0]  edit_voice;
  logic                edit_toggle;
  logic [VOICES-1:0]   pads;
  logic [VOICES-1:0]   trig;
  logic [STEP_W-1:0]   step_idx;
  logic                step_strobe;
  logic [STEPS-1:0]    edit_row;

  modport master (
    output mode, step_period, edit_step, edit_voice, edit_toggle, pads,
    input  trig, step_idx, step_strobe, edit_row
  );

  modport slave (
    input  mode, step_period, edit_step, edit_voice, edit_toggle, pads,
    output trig, step_idx, step_strobe, edit_row
  );

endinterface

// File: rtl/step_sequencer_timer.sv
// step_timer: counts clk cycles within a step and pulses tick on the last one.
// A period of 0 is treated as 1, so the tick then fires every enabled cycle.
module step_timer import drum_pkg::*; #(
  parameter int PERIOD_W = DRUM_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] last_cnt;

  // >= rather than == so a period shortened mid-step ends the step at once.
  always_comb begin
    last_cnt = (period == '0) ? '0 : period - PERIOD_W'(1);
    tick     = en && !clr && (timer_q >= last_cnt);
    timer_d  = timer_q + PERIOD_W'(1);
    if (clr || !en || tick) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

endmodule

// File: rtl/step_sequencer.sv
// Drum step sequencer: grid edit, timed pattern playback and raw pad triggering.
// Build option STEP_SEQUENCER_LIVE_EDIT_EN lets edit_toggle also flip the grid in PLAY.
module step_sequencer import drum_pkg::*; #(
  parameter int VOICES   = DRUM_VOICES,
  parameter int STEPS    = DRUM_STEPS,
  parameter int PERIOD_W = DRUM_PERIOD_W
) (
  input  logic             clk,
  input  logic             rst,
  step_sequencer_if.slave  bus
);

  localparam int STEP_W = $clog2(STEPS);

  sysmode_t                      mode, prev_mode_q, prev_mode_d;
  logic [VOICES-1:0][STEPS-1:0]  grid_q, grid_d;
  logic [VOICES-1:0]             trig_q, trig_d;
  logic [VOICES-1:0]             pads_q, pads_d;
  logic [VOICES-1:0]             col0, col_next;
  logic [STEP_W-1:0]             step_idx_q, step_idx_d, step_next;
  logic                          step_strobe_q, step_strobe_d;
  logic                          in_play, entry, tick, edit_en, voice_ok;

  assign mode      = decode_mode(bus.mode);
  assign in_play   = (mode == PLAY);
  assign entry     = in_play && (prev_mode_q != PLAY);
  assign voice_ok  = int'(bus.edit_voice) < VOICES;
  assign step_next = (step_idx_q == STEP_W'(STEPS - 1)) ? '0 : step_idx_q + STEP_W'(1);

`ifdef STEP_SEQUENCER_LIVE_EDIT_EN
  assign edit_en = (mode != RAW);
`else
  assign edit_en = (mode == EDIT);
`endif

  step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (entry),
    .en     (in_play),
    .period (bus.step_period),
    .tick   (tick)
  );

  always_comb begin
    col0     = '0;
    col_next = '0;
    for (int v = 0; v < VOICES; v++) begin
      col0[v]     = grid_q[v][0];
      col_next[v] = grid_q[v][step_next];
    end
  end

  // Triggers read grid_q, so a same-cycle toggle only affects later passes.
  always_comb begin
    grid_d        = grid_q;
    pads_d        = bus.pads;
    prev_mode_d   = mode;
    step_idx_d    = '0;
    trig_d        = '0;
    step_strobe_d = 1'b0;
    if (bus.edit_toggle && edit_en && voice_ok)
      grid_d[bus.edit_voice][bus.edit_step] = ~grid_q[bus.edit_voice][bus.edit_step];
    case (mode)
      PLAY: begin
        if (entry) begin
          trig_d        = col0;
          step_strobe_d = 1'b1;
        end else if (tick) begin
          step_idx_d    = step_next;
          trig_d        = col_next;
          step_strobe_d = 1'b1;
        end else begin
          step_idx_d    = step_idx_q;
        end
      end
      RAW:     trig_d = bus.pads & ~pads_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid_q        <= '0;
      trig_q        <= '0;
      pads_q        <= '0;
      step_idx_q    <= '0;
      step_strobe_q <= 1'b0;
      prev_mode_q   <= EDIT;
    end else begin
      grid_q        <= grid_d;
      trig_q        <= trig_d;
      pads_q        <= pads_d;
      step_idx_q    <= step_idx_d;
      step_strobe_q <= step_strobe_d;
      prev_mode_q   <= prev_mode_d;
    end
  end

  assign bus.trig        = trig_q;
  assign bus.step_idx    = step_idx_q;
  assign bus.step_strobe = step_strobe_q;
  assign bus.edit_row    = voice_ok ? grid_q[bus.edit_voice] : '0;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a cycle-level pattern model queues the
// expected outputs per clock; a monitor pops and compares them after each edge.
module tb_step_sequencer;

  localparam int VOICES   = 4;
  localparam int STEPS    = 16;
  localparam int PERIOD_W = 24;
`ifdef STEP_SEQUENCER_LIVE_EDIT_EN
  localparam bit LIVE = 1'b1;
`else
  localparam bit LIVE = 1'b0;
`endif

  typedef struct packed {
    logic [VOICES-1:0] trig;
    logic [3:0]        idx;
    logic              strobe;
    logic [STEPS-1:0]  row;
  } obs_t;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  step_sequencer_if #(.VOICES(VOICES), .STEPS(STEPS), .PERIOD_W(PERIOD_W)) bus ();

  step_sequencer #(.VOICES(VOICES), .STEPS(STEPS), .PERIOD_W(PERIOD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pattern grid, play position and cycles spent in that step.
  bit          gm [VOICES][STEPS];
  int          pos, dwell;
  bit          was_play;
  bit [VOICES-1:0] prev_pads;
  obs_t        expq [$];

  function automatic logic [VOICES-1:0] column(input int p);
    logic [VOICES-1:0] c;
    for (int v = 0; v < VOICES; v++) c[v] = gm[v][p];
    return c;
  endfunction

  function automatic logic [STEPS-1:0] row(input int v);
    logic [STEPS-1:0] r;
    r = '0;
    if (v < VOICES) for (int s = 0; s < STEPS; s++) r[s] = gm[v][s];
    return r;
  endfunction

  task automatic model_edge();
    obs_t e;
    int   m, eff, ev, es;
    e  = '0;
    ev = int'(bus.edit_voice);
    es = int'(bus.edit_step);
    if (rst) begin
      for (int v = 0; v < VOICES; v++)
        for (int s = 0; s < STEPS; s++) gm[v][s] = 1'b0;
      pos = 0; dwell = 0; was_play = 0; prev_pads = '0;
    end else begin
      m = (bus.mode == 2'd3) ? 0 : int'(bus.mode);
      if (m == 1) begin
        if (!was_play) begin
          pos = 0; dwell = 0;
          e.strobe = 1'b1; e.trig = column(0);
        end else begin
          eff = (bus.step_period == 0) ? 1 : int'(bus.step_period);
          if (dwell + 1 >= eff) begin
            pos = (pos + 1) % STEPS; dwell = 0;
            e.strobe = 1'b1; e.trig = column(pos);
          end else begin
            dwell++;
          end
        end
      end else begin
        pos = 0; dwell = 0;
        if (m == 2) e.trig = bus.pads & ~prev_pads;
      end
      if (bus.edit_toggle && ev < VOICES && (m == 0 || (LIVE && m == 1)))
        gm[ev][es] = !gm[ev][es];
      prev_pads = bus.pads;
      was_play  = (m == 1);
    end
    e.idx = 4'(pos);
    e.row = row(ev);
    expq.push_back(e);
  endtask

  // One clock: the model takes the edge, inputs may then change at negedge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic toggle(input int v, input int s);
    bus.edit_voice  = 2'(v);
    bus.edit_step   = 4'(s);
    bus.edit_toggle = 1'b1;
    cyc();
    bus.edit_toggle = 1'b0;
  endtask

  // Monitor: compares every post-edge output against the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {bus.trig, bus.step_idx, bus.step_strobe, bus.edit_row};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard at %0t: got trig=%b idx=%0d stb=%b row=%h expected trig=%b idx=%0d stb=%b row=%h",
                   $time, a.trig, a.idx, a.strobe, a.row, e.trig, e.idx, e.strobe, e.row);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.mode = 2'd0; bus.step_period = '0; bus.edit_step = '0; bus.edit_voice = '0;
    bus.edit_toggle = 1'b0; bus.pads = '0;
    @(negedge clk);
    cyc(3);
    chk("reset_trig", 32'(bus.trig), 0);
    chk("reset_idx", 32'(bus.step_idx), 0);
    rst = 1'b0;
    cyc();

    // EDIT toggles on voice1/step3
    toggle(1, 3);
    chk("edit_row_set", 32'(bus.edit_row), 32'h0008);
    toggle(1, 3);
    chk("edit_row_clr", 32'(bus.edit_row), 32'h0000);

    // Voice0 on every 4th step, period 4
    foreach (gm[0][s]) if (s % 4 == 0) toggle(0, s);
    bus.edit_voice = 2'd0;
    chk("row0_pattern", 32'(bus.edit_row), 32'h1111);
    bus.step_period = 24'd4;
    bus.mode = 2'd1;
    for (int n = 1; n <= 70; n++) begin
      cyc();
      chk("p4_trig", 32'(bus.trig), ((n - 1) % 16 == 0) ? 1 : 0);
      chk("p4_idx", 32'(bus.step_idx), ((n - 1) / 4) % 16);
      chk("p4_strobe", 32'(bus.step_strobe), ((n - 1) % 4 == 0) ? 1 : 0);
    end

    // Period 0 behaves as 1
    bus.mode = 2'd0; cyc();
    bus.step_period = '0; bus.mode = 2'd1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      chk("p0_idx", 32'(bus.step_idx), (n - 1) % 16);
    end

    // Exit PLAY mid-step, then re-enter
    bus.mode = 2'd0; cyc();
    bus.step_period = 24'd8; bus.mode = 2'd1;
    cyc(10);
    chk("mid_idx", 32'(bus.step_idx), 1);
    bus.mode = 2'd0; cyc();
    chk("exit_idx", 32'(bus.step_idx), 0);
    chk("exit_trig", 32'(bus.trig), 0);
    bus.mode = 2'd1; cyc();
    chk("reentry_trig", 32'(bus.trig), 32'b0001);
    chk("reentry_strobe", 32'(bus.step_strobe), 1);

    // RAW pad rising edges
    bus.mode = 2'd2; bus.pads = 4'b0000; cyc(2);
    bus.pads = 4'b0101;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      chk("raw_trig", 32'(bus.trig), (n == 1) ? 32'b0101 : 0);
    end
    bus.pads = 4'b0000;

    // Reset in the middle of PLAY clears grid too
    bus.step_period = 24'd3; bus.mode = 2'd1; cyc(6);
    rst = 1'b1; cyc();
    chk("rst_trig", 32'(bus.trig), 0);
    chk("rst_idx", 32'(bus.step_idx), 0);
    chk("rst_row", 32'(bus.edit_row), 0);
    rst = 1'b0; bus.mode = 2'd0; cyc();

    // Toggle in PLAY on the column about to fire
    toggle(2, 1);
    bus.edit_voice = 2'd2; bus.step_period = 24'd2; bus.mode = 2'd1;
    cyc(2);
    toggle(2, 1);
    chk("live_trig_old", 32'(bus.trig), 32'b0100);
    chk("live_row", 32'(bus.edit_row[1]), LIVE ? 0 : 1);
    bus.mode = 2'd3; cyc(2);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.step_period = 24'($urandom_range(0, 5));
      bus.edit_voice  = 2'($urandom_range(0, 3));
      bus.edit_step   = 4'($urandom_range(0, 15));
      bus.edit_toggle = ($urandom_range(0, 4) == 0);
      bus.pads        = 4'($urandom_range(0, 15));
      rst             = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; bus.edit_toggle = 1'b0;
    cyc(2);
    @(posedge clk); #2;
    chk("queue_drained", 32'(expq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Schedules drum voice triggers from a programmable step pattern.
- Sits downstream of the system mode controller and consumes its 2-bit mode.
- EDIT mode: the pattern grid is written. PLAY mode: the grid is stepped at a programmable period. RAW mode: pad presses go straight to the voices.
- Drives one-cycle trigger pulses to the voice/sample playback engines, plus step and pattern status for the LED display.

Parameters:
- VOICES, 4, number of drum voices (pattern rows, trigger outputs).
- STEPS, 16, steps per pattern (columns); power of two, at least 2.
- PERIOD_W, 24, width of the step_period input.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  system mode: 0 EDIT, 1 PLAY, 2 RAW, 3 treated as EDIT.
- step_period  in  PERIOD_W  clk cycles per step; 0 treated as 1.
- edit_step  in  $clog2(STEPS)  column addressed for editing.
- edit_voice  in  $clog2(VOICES)  row addressed for editing and display.
- edit_toggle  in  1  single-cycle strobe; flips the addressed grid bit.
- pads  in  VOICES  debounced, synchronous pad levels.
- trig  out  VOICES  one-cycle voice trigger pulses, registered.
- step_idx  out  $clog2(STEPS)  current play position.
- step_strobe  out  1  one-cycle pulse on each step boundary in PLAY.
- edit_row  out  STEPS  pattern row for edit_voice; combinational read of the grid.

Behaviour:
- Reset: grid all zero; trig=0, step_idx=0, step_strobe=0, timer=0, pads_q=0, prev_mode=EDIT.
- Grid update (EDIT, or mode 3): edit_toggle=1 inverts grid[edit_voice][edit_step]; the new value is visible on edit_row the next cycle.
  - Any edit_voice >= VOICES: toggle ignored, edit_row=0.
- EDIT idle state: step_idx, timer and trig held at 0; step_strobe=0.
- PLAY entry, first cycle with mode==PLAY and prev_mode!=PLAY:
  - step_idx<=0, timer<=0.
  - Following cycle: trig=grid column 0, step_strobe=1. Latency from mode change to first trig is one cycle.
- PLAY run:
  - timer increments each cycle.
  - When timer >= eff_period-1, where eff_period=max(step_period,1):
    - timer<=0;
    - step_idx<=step_idx+1, wrapping STEPS-1 to 0;
    - trig<=grid column of the new step;
    - step_strobe<=1.
  - Otherwise trig=0, step_strobe=0.
  - The >= compare means a step_period reduced mid-step advances on the next cycle.
- Same-cycle toggle and trigger on the same bit: trig uses the pre-toggle value.
- RAW: trig[i] <= pads[i] & ~pads_q[i] (rising edge); pads_q updates every cycle in every mode. step_idx=0, timer=0, step_strobe=0.
- Leaving PLAY mid-step: next cycle step_idx=0, timer=0, trig=0. No trig is issued on the exit cycle.
- rst asserted mid-PLAY: all state, including the grid, cleared next edge; rst has priority over mode and edit_toggle.
- Mode changes between non-PLAY modes: no side effects beyond gating trig sources.

Optional Feature:
- Macro: STEP_SEQUENCER_LIVE_EDIT_EN.
- Defined: edit_toggle is also honoured in PLAY. Same-cycle precedence rule as above applies.
- Undefined: edit_toggle is ignored outside EDIT/mode 3.

Decomposition:
- Shared package drum_pkg: sysmode_t enum (EDIT=0, PLAY=1, RAW=2), shared with the mode controller; default VOICES/STEPS constants.
- Sub-module step_timer: period counter with clear, enable and eff_period handling; outputs a tick pulse. The sequencer instantiates it once.

Test Plan:
- EDIT, toggle (voice1, step3) then (voice1, step3) again, edit_voice=1 -> edit_row 0x0008 after the first toggle, 0x0000 after the second.
- Grid voice0 steps {0,4,8,12}, step_period=4, mode->PLAY -> trig[0] at cycles 1, 17, 33, 49 after entry; step_strobe every 4 cycles; step_idx wraps 15->0 at cycle 65.
- step_period=0 in PLAY -> step advances every cycle; step_idx sequence 0,1,2,...,15,0.
- PLAY for 10 cycles at step_period=8 (mid-step 1), mode->EDIT, then back to PLAY -> step_idx 0 on exit; fresh column-0 trig one cycle after re-entry.
- RAW, pads=0b0000->0b0101, held 5 cycles -> trig=0b0101 for exactly one cycle, then 0.
- rst pulsed mid-PLAY with grid non-zero -> next cycle grid, trig, step_idx all 0; edit_row=0.
- With STEP_SEQUENCER_LIVE_EDIT_EN defined: toggle in PLAY on the column about to trigger -> trig uses the old value, edit_row shows the new value. Undefined: grid unchanged.
